pll_reset_sequencer: RTL
========================

Name: pll_reset_sequencer

Overview:
- Power-up and lock supervisor for the board rPLL that feeds the core clock.
- Runs on the 27 MHz board-oscillator clock, outside the PLL domain.
- Drives the PLL RESET pin, watches the asynchronous LOCK pin, and holds the system reset until lock has been stable for a programmable time.
- Retries the PLL on lock timeout, re-holds the system after any lock loss, and latches a fault after repeated failures.

Parameters:
- PLL_RST_CYCLES, 16: cycles pll_reset_o is held high per reset attempt (>=1).
- LOCK_TIMEOUT, 270000: cycles to wait for lock before retrying (10 ms at 27 MHz).
- STABLE_CYCLES, 1024: consecutive synchronized-lock cycles required before release.
- MAX_RETRIES, 3: PLL re-reset attempts allowed before FAULT.
- RW, 2: width of retry_cnt_o; must satisfy 2^RW > MAX_RETRIES.

Ports:
- clk  in  1  27 MHz board oscillator clock.
- rst  in  1  synchronous, active-high reset.
- pll_lock_i  in  1  PLL LOCK, asynchronous to clk.
- clear_fault_i  in  1  one-cycle pulse; leaves FAULT.
- pll_reset_o  out  1  to PLL RESET, active-high.
- sys_rst_o  out  1  system reset, active-high, synchronous to clk.
- ready_o  out  1  high only in RUN.
- fault_o  out  1  high only in FAULT.
- retry_cnt_o  out  RW  retries consumed since the last RUN entry or fault clear.
- state_o  out  3  encoding: RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4.

Behaviour:
Interface:
- One clock; reset is synchronous and active-high. Clock port is clk, reset port is rst.

Reset:
- While rst is high, at every edge: state=RESET_PLL, cnt=0, retry=0, lock sync FFs=0.
- Outputs during reset: pll_reset_o=1, sys_rst_o=1, ready_o=0, fault_o=0, retry_cnt_o=0, state_o=0.
- rst asserted mid-operation in any state, including FAULT, gives the same result at the next edge.

Outputs and synchronizer:
- All outputs are registered and decoded from the state register.
- pll_lock_i passes through a 2-FF synchronizer to lock_s. All decisions use lock_s only.

States:
- RESET_PLL: pll_reset_o=1, sys_rst_o=1.
  - cnt increments each cycle.
  - When cnt==PLL_RST_CYCLES-1: go to WAIT_LOCK, cnt=0.
- WAIT_LOCK: pll_reset_o=0, sys_rst_o=1.
  - lock_s=1: go to STABLE, cnt=0.
  - Else if cnt==LOCK_TIMEOUT-1 and retry==MAX_RETRIES: go to FAULT.
  - Else if cnt==LOCK_TIMEOUT-1: retry+1, go to RESET_PLL, cnt=0.
  - Otherwise cnt+1.
- STABLE: sys_rst_o=1.
  - lock_s=0: go to WAIT_LOCK, cnt=0. The timeout restarts and retry is unchanged.
  - Else if cnt==STABLE_CYCLES-1: go to RUN, retry=0.
  - Otherwise cnt+1.
- RUN: sys_rst_o=0, ready_o=1.
  - lock_s=0: go to WAIT_LOCK, cnt=0.
  - Lock loss alone never re-resets the PLL; that happens only via timeout.
- FAULT: pll_reset_o=1, sys_rst_o=1, fault_o=1.
  - Held indefinitely.
  - clear_fault_i=1: go to RESET_PLL, cnt=0, retry=0.
  - clear_fault_i is ignored in all other states.

Latencies:
- Lock rise at pin to ready_o=1: 2 sync + STABLE_CYCLES + 1 output cycles.
- Lock fall at pin during RUN to sys_rst_o=1: 3 cycles (2 sync + 1 state register).

Simultaneous events:
- lock_s=1 on the timeout cycle: lock wins (go to STABLE).
- lock_s=0 on the last STABLE cycle: loss wins (go to WAIT_LOCK).

Counters:
- cnt is $clog2(max(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)) bits wide.
- cnt never wraps: every terminal compare resets it.
- retry saturates at MAX_RETRIES.

Illegal state encodings (5-7): go to RESET_PLL at the next edge.

Test Plan:
Bench parameters: PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2.
1. Clean start: release rst, raise pll_lock_i 6 cycles later. Required:
   - pll_reset_o high for exactly 4 cycles.
   - state_o sequence 0, 1, 2, 3.
   - sys_rst_o falls and ready_o rises together, 8+2+1 cycles after lock rises at the pin.
   - retry_cnt_o=0.
2. Timeout retry: lock held low for 2 timeouts, then raised. Required:
   - pll_reset_o re-pulses (4 cycles) after each 20-cycle wait.
   - retry_cnt_o reads 1, then 2.
   - Reaches RUN and retry_cnt_o returns to 0.
3. Fault and clear: lock never rises. Required:
   - After 3 timeouts: state_o=4, fault_o=1, pll_reset_o=1, sys_rst_o=1; held for 100 cycles.
   - clear_fault_i pulse: state_o=0, retry_cnt_o=0 on the next cycle.
4. Lock glitch: in STABLE at cnt=5, drop lock for 1 cycle. Required:
   - Back to WAIT_LOCK, then STABLE restarts from cnt=0.
   - ready_o stays 0 until 8 full stable cycles pass.
5. Run-time loss: drop lock while in RUN. Required:
   - sys_rst_o=1 and ready_o=0 exactly 3 cycles later.
   - pll_reset_o stays 0.
   - Relock reaches RUN again without a PLL reset.
6. Mid-operation reset: assert rst for 1 cycle in each of STABLE, RUN and FAULT. Required:
   - All outputs equal their reset values on the next cycle.
   - The full sequence restarts from RESET_PLL.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// Power-up and lock supervisor for the board PLL: pulses PLL reset, waits for a stable
// synchronized lock, then releases the system reset; retries on timeout and latches a fault.
module pll_reset_sequencer #(
   parameter int unsigned PLL_RST_CYCLES = 16,
   parameter int unsigned LOCK_TIMEOUT   = 270000,
   parameter int unsigned STABLE_CYCLES  = 1024,
   parameter int unsigned MAX_RETRIES    = 3,
   parameter int unsigned RW             = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pll_lock_i,
   input  logic          clear_fault_i,
   output logic          pll_reset_o,
   output logic          sys_rst_o,
   output logic          ready_o,
   output logic          fault_o,
   output logic [RW-1:0] retry_cnt_o,
   output logic [2:0]    state_o
);

   localparam int unsigned MaxAB = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
   localparam int unsigned MaxC  = (MaxAB > STABLE_CYCLES) ? MaxAB : STABLE_CYCLES;
   localparam int unsigned CW    = (MaxC > 1) ? $clog2(MaxC) : 1;

   localparam logic [CW-1:0] CntRstLast = CW'(PLL_RST_CYCLES - 1);
   localparam logic [CW-1:0] CntToLast  = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] CntStbLast = CW'(STABLE_CYCLES - 1);
   localparam logic [RW-1:0] RetryMax   = RW'(MAX_RETRIES);

   typedef enum logic [2:0] {
      StResetPll = 3'd0,
      StWaitLock = 3'd1,
      StStable   = 3'd2,
      StRun      = 3'd3,
      StFault    = 3'd4
   } state_e;

   state_e        r_state;
   state_e        w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic [RW-1:0] r_retry;
   logic [RW-1:0] w_retry_nxt;
   logic          r_sync1;
   logic          r_lock_s;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= StResetPll;
         r_cnt    <= '0;
         r_retry  <= '0;
         r_sync1  <= 1'b0;
         r_lock_s <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_retry  <= w_retry_nxt;
         r_sync1  <= pll_lock_i;
         r_lock_s <= r_sync1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_retry_nxt = r_retry;
      case (r_state)
         StResetPll: begin
            if (r_cnt == CntRstLast) begin
               w_state_nxt = StWaitLock;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         StWaitLock: begin
            // Lock wins over a coincident timeout.
            if (r_lock_s) begin
               w_state_nxt = StStable;
               w_cnt_nxt   = '0;
            end else if (r_cnt == CntToLast) begin
               w_cnt_nxt = '0;
               if (r_retry == RetryMax) begin
                  w_state_nxt = StFault;
               end else begin
                  w_state_nxt = StResetPll;
                  w_retry_nxt = r_retry + RW'(1);
               end
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         StStable: begin
            if (!r_lock_s) begin
               w_state_nxt = StWaitLock;
               w_cnt_nxt   = '0;
            end else if (r_cnt == CntStbLast) begin
               w_state_nxt = StRun;
               w_cnt_nxt   = '0;
               w_retry_nxt = '0;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         StRun: begin
            // Lock loss only re-holds the system; the PLL is re-reset solely via timeout.
            if (!r_lock_s) begin
               w_state_nxt = StWaitLock;
               w_cnt_nxt   = '0;
            end
         end
         StFault: begin
            if (clear_fault_i) begin
               w_state_nxt = StResetPll;
               w_cnt_nxt   = '0;
               w_retry_nxt = '0;
            end
         end
         default: begin
            w_state_nxt = StResetPll;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_comb begin
      pll_reset_o = 1'b0;
      sys_rst_o   = 1'b1;
      ready_o     = 1'b0;
      fault_o     = 1'b0;
      case (r_state)
         StResetPll: pll_reset_o = 1'b1;
         StWaitLock: pll_reset_o = 1'b0;
         StStable:   pll_reset_o = 1'b0;
         StRun: begin
            sys_rst_o = 1'b0;
            ready_o   = 1'b1;
         end
         StFault: begin
            pll_reset_o = 1'b1;
            fault_o     = 1'b1;
         end
         default: pll_reset_o = 1'b1;
      endcase
   end

   assign retry_cnt_o = r_retry;
   assign state_o     = r_state;

endmodule
